// File: rtl/riscv_multicycle_core.sv
// Multi-cycle RV32I/RV32E subset core on one unified memory port with a ready handshake.
// Optional build macro RISCV_SHIFT_EN adds sll/srl/sra/slli/srli/srai.
module riscv_multicycle_core #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          NUM_REGS = 32
) (
    input  logic        clk,
    input  logic        reset,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ready,
    output logic [31:0] pc_current,
    output logic        retire,
    output logic        illegal
);
    localparam int IDX_W = (NUM_REGS == 16) ? 4 : 5;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_OP     = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;

    typedef enum logic [3:0] {
        S_FETCH, S_DECODE, S_EXEC_R, S_EXEC_I, S_MEMADR, S_MEMREAD, S_MEMWRITE,
        S_MEMWB, S_ALUWB, S_BRANCH, S_JAL, S_LUI, S_ILLEGAL
    } state_t;

    state_t      state_r, state_s;
    logic [31:0] pc_r, old_pc_r, instr_r, a_r, b_r, alu_out_r, mdr_r;
    logic        illegal_r;
    logic [31:0] regs_r [NUM_REGS];

    logic [6:0]  opcode_s, f7_s;
    logic [4:0]  rd_s, rs1_s, rs2_s;
    logic [2:0]  f3_s;
    logic [31:0] imm_i_s, imm_st_s, imm_b_s, imm_j_s, imm_u_s;
    logic [31:0] mem_ea_s, br_target_s, jal_target_s;
    logic        br_taken_s;

    // Only RV32E builds can name a register that does not exist.
    function automatic logic reg_bad(input logic [4:0] idx);
        return (NUM_REGS == 16) && idx[4];
    endfunction

    function automatic logic r_type_ok(input logic [2:0] f3, input logic [6:0] f7);
        logic ok;
        ok = 1'b0;
        case (f3)
            3'b000:                 ok = (f7 == 7'b0000000) || (f7 == 7'b0100000);
            3'b010, 3'b110, 3'b111: ok = (f7 == 7'b0000000);
`ifdef RISCV_SHIFT_EN
            3'b001:                 ok = (f7 == 7'b0000000);
            3'b101:                 ok = (f7 == 7'b0000000) || (f7 == 7'b0100000);
`endif
            default:                ok = 1'b0;
        endcase
        return ok;
    endfunction

    function automatic logic i_type_ok(input logic [2:0] f3, input logic [6:0] f7);
        logic ok;
        ok = 1'b0;
        case (f3)
            3'b000, 3'b010, 3'b110, 3'b111: ok = 1'b1;
`ifdef RISCV_SHIFT_EN
            3'b001:                         ok = (f7 == 7'b0000000);
            3'b101:                         ok = (f7 == 7'b0000000) || (f7 == 7'b0100000);
`endif
            default:                        ok = 1'b0;
        endcase
        return ok;
    endfunction

    function automatic logic [31:0] alu(input logic [31:0] a, input logic [31:0] b,
                                        input logic [2:0] f3, input logic alt);
        logic [31:0] y;
        y = 32'd0;
        case (f3)
            3'b000:  y = alt ? (a - b) : (a + b);
            3'b010:  y = {31'd0, $signed(a) < $signed(b)};
            3'b110:  y = a | b;
            3'b111:  y = a & b;
`ifdef RISCV_SHIFT_EN
            3'b001:  y = a << b[4:0];
            3'b101:  y = alt ? 32'($signed(a) >>> b[4:0]) : (a >> b[4:0]);
`endif
            default: y = 32'd0;
        endcase
        return y;
    endfunction

    assign opcode_s = instr_r[6:0];
    assign rd_s     = instr_r[11:7];
    assign f3_s     = instr_r[14:12];
    assign rs1_s    = instr_r[19:15];
    assign rs2_s    = instr_r[24:20];
    assign f7_s     = instr_r[31:25];

    assign imm_i_s  = {{20{instr_r[31]}}, instr_r[31:20]};
    assign imm_st_s = {{20{instr_r[31]}}, instr_r[31:25], instr_r[11:7]};
    assign imm_b_s  = {{19{instr_r[31]}}, instr_r[31], instr_r[7], instr_r[30:25], instr_r[11:8], 1'b0};
    assign imm_j_s  = {{11{instr_r[31]}}, instr_r[31], instr_r[19:12], instr_r[20], instr_r[30:21], 1'b0};
    assign imm_u_s  = {instr_r[31:12], 12'd0};

    assign mem_ea_s     = a_r + (opcode_s[5] ? imm_st_s : imm_i_s);
    assign br_taken_s   = f3_s[0] ? (a_r != b_r) : (a_r == b_r);
    assign br_target_s  = old_pc_r + imm_b_s;
    assign jal_target_s = old_pc_r + imm_j_s;

    assign mem_wdata = b_r;
    assign illegal   = illegal_r;

    // Next-state decode, including every fault that diverts to the halt state.
    always_comb begin
        state_s = state_r;
        case (state_r)
            S_FETCH:    state_s = mem_ready ? S_DECODE : S_FETCH;
            S_DECODE: begin
                case (opcode_s)
                    OP_OP:     state_s = (r_type_ok(f3_s, f7_s) && !reg_bad(rd_s) && !reg_bad(rs1_s)
                                          && !reg_bad(rs2_s)) ? S_EXEC_R : S_ILLEGAL;
                    OP_IMM:    state_s = (i_type_ok(f3_s, f7_s) && !reg_bad(rd_s) && !reg_bad(rs1_s))
                                         ? S_EXEC_I : S_ILLEGAL;
                    OP_LOAD:   state_s = ((f3_s == 3'b010) && !reg_bad(rd_s) && !reg_bad(rs1_s))
                                         ? S_MEMADR : S_ILLEGAL;
                    OP_STORE:  state_s = ((f3_s == 3'b010) && !reg_bad(rs1_s) && !reg_bad(rs2_s))
                                         ? S_MEMADR : S_ILLEGAL;
                    OP_BRANCH: state_s = ((f3_s[2:1] == 2'b00) && !reg_bad(rs1_s) && !reg_bad(rs2_s))
                                         ? S_BRANCH : S_ILLEGAL;
                    OP_JAL:    state_s = !reg_bad(rd_s) ? S_JAL : S_ILLEGAL;
                    OP_LUI:    state_s = !reg_bad(rd_s) ? S_LUI : S_ILLEGAL;
                    default:   state_s = S_ILLEGAL;
                endcase
            end
            S_EXEC_R, S_EXEC_I, S_LUI: state_s = S_ALUWB;
            S_MEMADR:   state_s = (mem_ea_s[1:0] != 2'b00) ? S_ILLEGAL
                                  : (opcode_s[5] ? S_MEMWRITE : S_MEMREAD);
            S_MEMREAD:  state_s = mem_ready ? S_MEMWB : S_MEMREAD;
            S_MEMWRITE: state_s = mem_ready ? S_FETCH : S_MEMWRITE;
            S_MEMWB, S_ALUWB: state_s = S_FETCH;
            S_BRANCH:   state_s = (br_taken_s && br_target_s[1]) ? S_ILLEGAL : S_FETCH;
            S_JAL:      state_s = jal_target_s[1] ? S_ILLEGAL : S_ALUWB;
            S_ILLEGAL:  state_s = S_ILLEGAL;
            default:    state_s = S_FETCH;
        endcase
    end

    // Memory port and status outputs; reset low masks request and retire immediately.
    always_comb begin
        mem_req    = 1'b0;
        mem_we     = 1'b0;
        retire     = 1'b0;
        mem_addr   = alu_out_r;
        pc_current = old_pc_r;
        case (state_r)
            S_FETCH: begin
                mem_req    = reset;
                mem_addr   = pc_r;
                pc_current = pc_r;
            end
            S_MEMREAD:        mem_req = reset;
            S_MEMWRITE: begin
                mem_req = reset;
                mem_we  = reset;
                retire  = reset & mem_ready;
            end
            S_MEMWB, S_ALUWB: retire = reset;
            S_BRANCH:         retire = reset & (state_s != S_ILLEGAL);
            default:          retire = 1'b0;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_r <= S_FETCH;
        end else begin
            state_r <= state_s;
        end
    end

    // Datapath registers and register file.
    always_ff @(posedge clk) begin
        if (!reset) begin
            pc_r      <= RESET_PC;
            old_pc_r  <= RESET_PC;
            instr_r   <= 32'd0;
            a_r       <= 32'd0;
            b_r       <= 32'd0;
            alu_out_r <= 32'd0;
            mdr_r     <= 32'd0;
            illegal_r <= 1'b0;
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_r[i] <= 32'd0;
            end
        end else begin
            illegal_r <= illegal_r | (state_s == S_ILLEGAL);
            case (state_r)
                S_FETCH: begin
                    if (mem_ready) begin
                        instr_r  <= mem_rdata;
                        old_pc_r <= pc_r;
                        pc_r     <= pc_r + 32'd4;
                    end
                end
                S_DECODE: begin
                    a_r <= regs_r[rs1_s[IDX_W-1:0]];
                    b_r <= regs_r[rs2_s[IDX_W-1:0]];
                end
                S_EXEC_R:  alu_out_r <= alu(a_r, b_r, f3_s, instr_r[30]);
                S_EXEC_I:  alu_out_r <= alu(a_r, imm_i_s, f3_s, (f3_s == 3'b101) && instr_r[30]);
                S_MEMADR:  alu_out_r <= mem_ea_s;
                S_MEMREAD: begin
                    if (mem_ready) begin
                        mdr_r <= mem_rdata;
                    end
                end
                S_MEMWB, S_ALUWB: begin
                    if (rd_s != 5'd0) begin
                        regs_r[rd_s[IDX_W-1:0]] <= (state_r == S_MEMWB) ? mdr_r : alu_out_r;
                    end
                end
                S_BRANCH: begin
                    if (br_taken_s && !br_target_s[1]) begin
                        pc_r <= br_target_s;
                    end
                end
                S_JAL: begin
                    if (!jal_target_s[1]) begin
                        pc_r      <= jal_target_s;
                        alu_out_r <= old_pc_r + 32'd4;
                    end
                end
                S_LUI:     alu_out_r <= imm_u_s;
                default:   alu_out_r <= alu_out_r;
            endcase
        end
    end
endmodule

// File: tb/tb_riscv_multicycle_core.sv
// Directed self-checking bench for riscv_multicycle_core (RESET_PC = 0x100); each program
// is entered through a jal x0 trampoline at 0x100 and ends on an illegal word.
`timescale 1ns/1ps
module tb_riscv_multicycle_core;
    logic        clk = 1'b0;
    logic        reset;
    logic        mem_req, mem_we, mem_ready, retire, illegal;
    logic [31:0] mem_addr, mem_wdata, mem_rdata, pc_current;

    logic [31:0] prog [256];
    logic [31:0] mem  [256];
    int          wait_n = 0;
    int          stall_cnt, stall_total, stall_changes, cyc, wr_cnt;
    logic        prev_stall;
    logic [64:0] prev_bus;
    logic [31:0] wr_addr, wr_data;
    int          ret_cyc [$];
    logic [31:0] rd_addr [$];
    int          errors = 0;
    int          checks = 0;

    riscv_multicycle_core #(.RESET_PC(32'h100), .NUM_REGS(32)) dut (
        .clk(clk), .reset(reset), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
        .pc_current(pc_current), .retire(retire), .illegal(illegal)
    );

    always #5 clk = ~clk;

    assign mem_ready = (stall_cnt >= wait_n);
    assign mem_rdata = mem[mem_addr[9:2]];

    // Memory model with programmable wait states, plus retire/transaction logging.
    always @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i < 256; i++) mem[i] <= prog[i];
            cyc <= 0; stall_cnt <= 0; stall_total <= 0; stall_changes <= 0;
            prev_stall <= 1'b0; wr_cnt <= 0;
            ret_cyc.delete(); rd_addr.delete();
        end else begin
            cyc <= cyc + 1;
            if (retire) ret_cyc.push_back(cyc + 1);
            if (mem_req && mem_ready) begin
                stall_cnt <= 0;
                if (mem_we) begin
                    mem[mem_addr[9:2]] <= mem_wdata;
                    wr_cnt <= wr_cnt + 1; wr_addr <= mem_addr; wr_data <= mem_wdata;
                end else begin
                    rd_addr.push_back(mem_addr);
                end
            end else if (mem_req) begin
                stall_cnt <= stall_cnt + 1; stall_total <= stall_total + 1;
            end
            if (prev_stall && mem_req && ({mem_we, mem_addr, mem_wdata} != prev_bus))
                stall_changes <= stall_changes + 1;
            prev_stall <= mem_req && !mem_ready;
            prev_bus   <= {mem_we, mem_addr, mem_wdata};
        end
    end

    function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rs2,
                                          input logic [4:0] rs1, input logic [2:0] f3, input logic [4:0] rd);
        return {f7, rs2, rs1, f3, rd, 7'b0110011};
    endfunction
    function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [4:0] rs1,
                                          input logic [2:0] f3, input logic [4:0] rd, input logic [6:0] op);
        return {imm, rs1, f3, rd, op};
    endfunction
    function automatic logic [31:0] enc_s(input logic [11:0] imm, input logic [4:0] rs2, input logic [4:0] rs1);
        return {imm[11:5], rs2, rs1, 3'b010, imm[4:0], 7'b0100011};
    endfunction
    function automatic logic [31:0] enc_b(input logic [12:0] off, input logic [4:0] rs2,
                                          input logic [4:0] rs1, input logic [2:0] f3);
        return {off[12], off[10:5], rs2, rs1, f3, off[4:1], off[11], 7'b1100011};
    endfunction
    function automatic logic [31:0] enc_j(input logic [4:0] rd, input logic [20:0] off);
        return {off[20], off[10:1], off[11], off[19:12], rd, 7'b1101111};
    endfunction
    function automatic logic [31:0] enc_u(input logic [19:0] imm, input logic [4:0] rd);
        return {imm, rd, 7'b0110111};
    endfunction

    task automatic new_prog(input logic [31:0] target);
        logic [31:0] off;
        for (int i = 0; i < 256; i++) prog[i] = 32'd0;
        off = target - 32'h100;
        prog[64] = enc_j(5'd0, off[20:0]);
    endtask

    task automatic do_reset();
        reset = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic wait_halt(input int budget, input string name);
        int n;
        n = 0;
        while (!illegal && n < budget) begin @(negedge clk); n++; end
        checks++;
        if (illegal !== 1'b1) begin errors++; $display("FAIL %s_halt: no halt within %0d cycles", name, budget); end
    endtask

    task automatic load_basic();
        prog[0] = enc_i(12'd5, 5'd0, 3'b000, 5'd1, 7'b0010011);
        prog[1] = enc_i(12'hFFD, 5'd0, 3'b000, 5'd2, 7'b0010011);
        prog[2] = enc_r(7'd0, 5'd2, 5'd1, 3'b000, 5'd3);
        prog[3] = enc_r(7'd0, 5'd1, 5'd2, 3'b010, 5'd4);
        prog[4] = enc_s(12'd8, 5'd3, 5'd0);
        prog[5] = enc_i(12'd8, 5'd0, 3'b010, 5'd5, 7'b0000011);
        prog[6] = 32'hFFFF_FFFF;
    endtask

    task automatic test_reset();
        wait_n = 0; new_prog(32'h0); prog[0] = 32'hFFFF_FFFF;
        reset = 1'b0;
        @(negedge clk);
        checks++; if ({mem_req, mem_we, retire, illegal} !== 4'b0000) begin errors++;
            $display("FAIL rst_outs got=%b exp=0000", {mem_req, mem_we, retire, illegal}); end
        @(negedge clk);
        checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL rst_req2 got=%b exp=0", mem_req); end
        reset = 1'b1;
        #1;
        checks++; if ({mem_req, mem_we} !== 2'b10) begin errors++;
            $display("FAIL rst_first_req got=%b exp=10", {mem_req, mem_we}); end
        checks++; if (mem_addr !== 32'h100) begin errors++; $display("FAIL rst_addr got=%h exp=100", mem_addr); end
        checks++; if (pc_current !== 32'h100) begin errors++; $display("FAIL rst_pc got=%h exp=100", pc_current); end
    endtask

    task automatic test_zero_wait();
        int span;
        wait_n = 0; new_prog(32'h0); load_basic();
        do_reset(); wait_halt(200, "zw");
        checks++; if (dut.regs_r[3] !== 32'd2) begin errors++; $display("FAIL zw_x3 got=%h exp=2", dut.regs_r[3]); end
        checks++; if (dut.regs_r[4] !== 32'd1) begin errors++; $display("FAIL zw_x4 got=%h exp=1", dut.regs_r[4]); end
        checks++; if (dut.regs_r[5] !== 32'd2) begin errors++; $display("FAIL zw_x5 got=%h exp=2", dut.regs_r[5]); end
        checks++; if (dut.regs_r[2] !== 32'hFFFF_FFFD) begin errors++; $display("FAIL zw_x2 got=%h exp=fffffffd", dut.regs_r[2]); end
        checks++; if ({wr_cnt, wr_addr, wr_data} !== {32'd1, 32'd8, 32'd2}) begin errors++;
            $display("FAIL zw_store got cnt=%0d addr=%h data=%h exp 1/8/2", wr_cnt, wr_addr, wr_data); end
        checks++; if (ret_cyc.size() !== 7) begin errors++; $display("FAIL zw_retires got=%0d exp=7", ret_cyc.size()); end
        span = (ret_cyc.size() == 7) ? ret_cyc[6] - ret_cyc[0] : -1;
        checks++; if (span !== 25) begin errors++; $display("FAIL zw_cycles got=%0d exp=25", span); end
        checks++; if (pc_current !== 32'h18) begin errors++; $display("FAIL zw_halt_pc got=%h exp=18", pc_current); end
    endtask

    task automatic test_wait_states();
        int span;
        wait_n = 3; new_prog(32'h0); load_basic();
        do_reset(); wait_halt(400, "ws");
        checks++; if ({dut.regs_r[3], dut.regs_r[4], dut.regs_r[5]} !== {32'd2, 32'd1, 32'd2}) begin errors++;
            $display("FAIL ws_regs got=%h %h %h exp=2 1 2", dut.regs_r[3], dut.regs_r[4], dut.regs_r[5]); end
        checks++; if ({wr_addr, wr_data} !== {32'd8, 32'd2}) begin errors++;
            $display("FAIL ws_store got addr=%h data=%h exp 8/2", wr_addr, wr_data); end
        span = (ret_cyc.size() == 7) ? ret_cyc[6] - ret_cyc[0] : -1;
        // 8 program transactions x 3 wait cycles on top of the 25 zero-wait cycles.
        checks++; if (span !== 49) begin errors++; $display("FAIL ws_cycles got=%0d exp=49", span); end
        checks++; if (stall_total !== 30) begin errors++; $display("FAIL ws_stalls got=%0d exp=30", stall_total); end
        checks++; if (stall_changes !== 0) begin errors++; $display("FAIL ws_bus_stable got=%0d exp=0", stall_changes); end
        wait_n = 0;
    endtask

    task automatic test_branch_jal();
        wait_n = 0; new_prog(32'h0);
        prog[0] = enc_b(13'd8, 5'd0, 5'd0, 3'b000);
        prog[1] = 32'hFFFF_FFFF;
        prog[2] = enc_j(5'd1, 21'h1FFFFC);
        do_reset(); wait_halt(100, "br");
        checks++; if (rd_addr.size() !== 4) begin errors++; $display("FAIL br_fetches got=%0d exp=4", rd_addr.size()); end
        else begin
            checks++; if ({rd_addr[1], rd_addr[2], rd_addr[3]} !== {32'h0, 32'h8, 32'h4}) begin errors++;
                $display("FAIL br_pc_seq got=%h %h %h exp=0 8 4", rd_addr[1], rd_addr[2], rd_addr[3]); end
        end
        checks++; if (dut.regs_r[1] !== 32'hC) begin errors++; $display("FAIL br_x1 got=%h exp=c", dut.regs_r[1]); end
        checks++; if (ret_cyc.size() !== 3) begin errors++; $display("FAIL br_retires got=%0d exp=3", ret_cyc.size()); end
        else begin
            checks++; if (ret_cyc[1] - ret_cyc[0] !== 3) begin errors++;
                $display("FAIL br_beq_lat got=%0d exp=3", ret_cyc[1] - ret_cyc[0]); end
            checks++; if (ret_cyc[2] - ret_cyc[1] !== 4) begin errors++;
                $display("FAIL br_jal_lat got=%0d exp=4", ret_cyc[2] - ret_cyc[1]); end
        end
    endtask

    task automatic test_illegal();
        int busy;
        wait_n = 0; new_prog(32'h20); prog[8] = 32'hFFFF_FFFF;
        do_reset(); wait_halt(100, "ill");
        checks++; if (pc_current !== 32'h20) begin errors++; $display("FAIL ill_pc got=%h exp=20", pc_current); end
        busy = 0;
        repeat (20) begin @(negedge clk); if (mem_req || retire) busy++; end
        checks++; if (busy !== 0) begin errors++; $display("FAIL ill_quiet got=%0d exp=0", busy); end
        checks++; if ({illegal, ret_cyc.size()} !== {1'b1, 32'd1}) begin errors++;
            $display("FAIL ill_sticky got ill=%b ret=%0d exp 1/1", illegal, ret_cyc.size()); end
        reset = 1'b0;
        @(negedge clk);
        checks++; if (illegal !== 1'b0) begin errors++; $display("FAIL ill_clear got=%b exp=0", illegal); end
        reset = 1'b1;
    endtask

    task automatic test_alu_misc();
        wait_n = 0; new_prog(32'h0);
        prog[0]  = enc_i(12'd90, 5'd0, 3'b000, 5'd1, 7'b0010011);
        prog[1]  = enc_i(12'd15, 5'd1, 3'b111, 5'd2, 7'b0010011);
        prog[2]  = enc_i(12'h100, 5'd1, 3'b110, 5'd3, 7'b0010011);
        prog[3]  = enc_i(12'hFFF, 5'd1, 3'b010, 5'd4, 7'b0010011);
        prog[4]  = enc_r(7'h20, 5'd1, 5'd2, 3'b000, 5'd5);
        prog[5]  = enc_r(7'd0, 5'd3, 5'd1, 3'b111, 5'd6);
        prog[6]  = enc_r(7'd0, 5'd3, 5'd2, 3'b110, 5'd7);
        prog[7]  = enc_b(13'd8, 5'd1, 5'd6, 3'b001);
        prog[8]  = enc_b(13'd8, 5'd1, 5'd2, 3'b001);
        prog[9]  = enc_i(12'd1, 5'd0, 3'b000, 5'd9, 7'b0010011);
        prog[10] = enc_i(12'd5, 5'd0, 3'b000, 5'd0, 7'b0010011);
        prog[11] = enc_i(12'd2, 5'd0, 3'b010, 5'd11, 7'b0000011);
        do_reset(); wait_halt(200, "alu");
        checks++; if ({dut.regs_r[2], dut.regs_r[3], dut.regs_r[4]} !== {32'hA, 32'h15A, 32'h0}) begin errors++;
            $display("FAIL alu_imm got=%h %h %h exp=a 15a 0", dut.regs_r[2], dut.regs_r[3], dut.regs_r[4]); end
        checks++; if ({dut.regs_r[5], dut.regs_r[6], dut.regs_r[7]} !== {32'hFFFF_FFB0, 32'h5A, 32'h15A}) begin errors++;
            $display("FAIL alu_reg got=%h %h %h exp=ffffffb0 5a 15a", dut.regs_r[5], dut.regs_r[6], dut.regs_r[7]); end
        checks++; if ({dut.regs_r[9], dut.regs_r[0], dut.regs_r[11]} !== 96'd0) begin errors++;
            $display("FAIL alu_skip_x0 got=%h %h %h exp=0 0 0", dut.regs_r[9], dut.regs_r[0], dut.regs_r[11]); end
        checks++; if (pc_current !== 32'h2C) begin errors++; $display("FAIL alu_misalign_pc got=%h exp=2c", pc_current); end
        checks++; if (ret_cyc.size() !== 11) begin errors++; $display("FAIL alu_retires got=%0d exp=11", ret_cyc.size()); end
    endtask

    task automatic test_shift();
        wait_n = 0; new_prog(32'h0);
        prog[0] = enc_u(20'h80000, 5'd1);
        prog[1] = enc_i(12'd1, 5'd1, 3'b000, 5'd1, 7'b0010011);
        prog[2] = enc_i(12'd4, 5'd0, 3'b000, 5'd3, 7'b0010011);
        prog[3] = enc_r(7'd0, 5'd3, 5'd1, 3'b001, 5'd2);
        prog[4] = enc_i(12'h41F, 5'd1, 3'b101, 5'd4, 7'b0010011);
        prog[5] = enc_r(7'd0, 5'd3, 5'd1, 3'b101, 5'd5);
        prog[6] = 32'hFFFF_FFFF;
        do_reset(); wait_halt(200, "sh");
        checks++; if (dut.regs_r[1] !== 32'h8000_0001) begin errors++; $display("FAIL sh_lui got=%h exp=80000001", dut.regs_r[1]); end
`ifdef RISCV_SHIFT_EN
        checks++; if (dut.regs_r[2] !== 32'h10) begin errors++; $display("FAIL sh_sll got=%h exp=10", dut.regs_r[2]); end
        checks++; if (dut.regs_r[4] !== 32'hFFFF_FFFF) begin errors++; $display("FAIL sh_srai got=%h exp=ffffffff", dut.regs_r[4]); end
        checks++; if (dut.regs_r[5] !== 32'h0800_0000) begin errors++; $display("FAIL sh_srl got=%h exp=08000000", dut.regs_r[5]); end
        checks++; if (pc_current !== 32'h18) begin errors++; $display("FAIL sh_halt_pc got=%h exp=18", pc_current); end
`else
        checks++; if (pc_current !== 32'hC) begin errors++; $display("FAIL sh_ill_pc got=%h exp=c", pc_current); end
        checks++; if (dut.regs_r[2] !== 32'd0) begin errors++; $display("FAIL sh_no_wb got=%h exp=0", dut.regs_r[2]); end
`endif
    endtask

    initial begin
        test_reset();
        test_zero_wait();
        test_wait_states();
        test_branch_jal();
        test_illegal();
        test_alu_misc();
        test_shift();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
